fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default 66, payload width in bits (instruction word, PC and status bits).
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two and at least 2.
REQ-003 Parameter AFULL_MARGIN, default 2, number of free entries at or below which almost_full asserts; range 1 to DEPTH-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  branch-mispredict flush; discards all queued entries.
REQ-007 enq_valid  input  1  producer (fetch) offers enq_data this cycle.
REQ-008 enq_data  input  WIDTH  payload to enqueue.
REQ-009 enq_ready  output  1  queue can accept an entry this cycle.
REQ-010 deq_valid  output  1  deq_data holds the oldest valid entry.
REQ-011 deq_data  output  WIDTH  oldest entry, first-word-fall-through.
REQ-012 deq_ready  input  1  consumer (decode/dispatch) takes deq_data this cycle.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-014 empty  output  1  count == 0.
REQ-015 full  output  1  count == DEPTH.
REQ-016 almost_full  output  1  DEPTH - count <= AFULL_MARGIN.

Function
REQ-017 An enqueue SHALL occur on a rising edge where enq_valid and enq_ready are both 1; a dequeue SHALL occur where deq_valid and deq_ready are both 1.
REQ-018 enq_ready SHALL be !full, except that with a dequeue in the same cycle a full queue SHALL also accept (enq_ready = !full | deq_ready).
REQ-019 Storage SHALL be a circular buffer: head and tail pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 by natural overflow.
REQ-020 deq_data SHALL be mem[head] combinationally, and deq_valid SHALL be !empty; payload order SHALL be strict FIFO.
REQ-021 Enqueue-only SHALL write mem[tail], advance tail and increment count; dequeue-only SHALL advance head and decrement count.
REQ-022 Simultaneous enqueue and dequeue SHALL advance both pointers and leave count unchanged, including when full.
REQ-023 An entry enqueued at edge N SHALL appear on deq_data from edge N onward when it becomes the oldest entry; minimum enqueue-to-deq_valid latency is one cycle.
REQ-024 Any enq_valid or deq_ready activity while the handshake is not met SHALL change no state.
REQ-025 flush SHALL take priority: at the edge it is high, head, tail and count SHALL reset to 0 and any same-cycle enqueue or dequeue SHALL be discarded.
REQ-026 deq_data SHALL be don't-care when deq_valid is 0; the bench SHALL NOT check it then.
REQ-027 count, empty, full and almost_full SHALL be derived from registered state only, with no combinational path from enq_valid or deq_ready.

Reset
REQ-028 While rst is 0: head=0, tail=0, count=0, deq_valid=0, empty=1, full=0, almost_full=0, enq_ready=1.
REQ-029 Storage contents SHALL NOT be reset; reset asserted mid-operation SHALL discard all entries immediately (asynchronously).

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN: when defined, an enqueue into an empty queue with deq_ready=1 SHALL present enq_data on deq_data with deq_valid=1 in the same cycle and SHALL NOT be stored; count SHALL remain 0.
REQ-031 When FETCH_QUEUE_BYPASS_EN is defined and the queue is not empty, and whenever FETCH_QUEUE_BYPASS_EN is undefined, behaviour SHALL follow REQ-017..REQ-027 exactly, with no combinational path from enq_* to deq_*.

Verification
REQ-032 Reset, then enqueue 0x11,0x22,0x33 on consecutive cycles with deq_ready=0 -> count=3, deq_data=0x11, then deq_ready=1 for three cycles -> 0x11,0x22,0x33 in order, empty=1.
REQ-033 Fill DEPTH=8 entries -> full=1, enq_ready=0 while deq_ready=0; almost_full=1 from count=6.
REQ-034 Full queue with enq_valid=1 and deq_ready=1 for 20 cycles -> count stays 8, pointers wrap at least twice, output order is preserved.
REQ-035 Enqueue 5 entries, assert flush together with enq_valid=1 and deq_ready=1 -> next cycle count=0, empty=1 and the flush-cycle entry is absent.
REQ-036 Drop rst to 0 mid-stream with 4 entries queued -> deq_valid=0 and count=0 before the next clock edge; after release, the first enqueue of 0xAA dequeues as 0xAA.
REQ-037 With FETCH_QUEUE_BYPASS_EN, empty queue, enq_valid=1, enq_data=0x5A, deq_ready=1 -> deq_valid=1 and deq_data=0x5A in the same cycle, count=0 afterwards; without the macro -> deq_valid=0 that cycle and 0x5A appears next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular-buffer instruction fetch queue with first-word-fall-through
// output, branch-mispredict flush and occupancy flags.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, an enqueue into
// an empty queue while the consumer is ready is forwarded straight to deq_*
// in the same cycle and is not stored.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   flush        discard all queued entries (wins over same-cycle enq/deq)
//   enq_valid    producer offers enq_data
//   enq_data     payload to enqueue
//   enq_ready    queue accepts this cycle (!full | deq_ready)
//   deq_valid    deq_data holds the oldest entry
//   deq_data     oldest entry (combinational read of the head slot)
//   deq_ready    consumer takes deq_data
//   count        current occupancy
//   empty/full   count == 0 / count == DEPTH
//   almost_full  free entries <= AFULL_MARGIN
module fetch_queue #(
  parameter int unsigned WIDTH        = 66,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [WIDTH-1:0]           enq_data,
  output logic                       enq_ready,
  output logic                       deq_valid,
  output logic [WIDTH-1:0]           deq_data,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_margin_chk
    $error("fetch_queue: AFULL_MARGIN must be in 1..DEPTH-1");
  end

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_deq;
  logic wr_en;
  logic mem_we;

  // Status flags come from the registered count only.
  always_comb begin
    count       = count_q;
    empty       = (count_q == '0);
    full        = (count_q == CNT_W'(DEPTH));
    almost_full = ((DEPTH - 32'(count_q)) <= AFULL_MARGIN);
  end

  // Handshakes and output datapath.
  always_comb begin
    enq_ready = !full || deq_ready;
    deq_valid = !empty;
    deq_data  = mem_q[head_q];
    do_deq    = !empty && deq_ready;
    wr_en     = enq_valid && enq_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with a ready consumer: forward the offered word, store nothing.
    if (empty && enq_valid && deq_ready) begin
      deq_valid = 1'b1;
      deq_data  = enq_data;
      wr_en     = 1'b0;
    end
`endif
    mem_we = wr_en && !flush;
  end

  // Pointer and occupancy next-state; flush overrides any handshake.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (do_deq) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({wr_en, do_deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[tail_q] <= enq_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a
// queue-based reference model of the FIFO rules.
module tb_fetch_queue;

  localparam int unsigned W     = 66;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFM   = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          enq_valid;
  logic [W-1:0]  enq_data;
  logic          enq_ready;
  logic          deq_valid;
  logic [W-1:0]  deq_data;
  logic          deq_ready;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;

  int n_cmp;
  int n_mis;

  logic [W-1:0] mq[$];

  fetch_queue #(.WIDTH(W), .DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, update the model after the edge.
  task automatic cycle(input string tag, input logic ev, input logic [W-1:0] d,
                       input logic dr, input logic fl);
    int sz;
    bit byp;
    bit exp_rdy;
    bit do_enq;
    bit do_deq;
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    flush     = fl;
    @(negedge clk);
    sz      = mq.size();
    byp     = BYP && (sz == 0) && ev && dr;
    exp_rdy = (sz < int'(DEPTH)) || dr;
    chk({tag, ".count"}, 128'(count), 128'(sz));
    chk({tag, ".empty"}, 128'(empty), 128'(sz == 0));
    chk({tag, ".full"}, 128'(full), 128'(sz == int'(DEPTH)));
    chk({tag, ".afull"}, 128'(almost_full), 128'((int'(DEPTH) - sz) <= int'(AFM)));
    chk({tag, ".enq_ready"}, 128'(enq_ready), 128'(exp_rdy));
    chk({tag, ".deq_valid"}, 128'(deq_valid), 128'((sz > 0) || byp));
    if (byp) chk({tag, ".deq_data_byp"}, 128'(deq_data), 128'(d));
    else if (sz > 0) chk({tag, ".deq_data"}, 128'(deq_data), 128'(mq[0]));
    do_enq = ev && exp_rdy && !byp;
    do_deq = (sz > 0) && dr;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back(d);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;

    // Reset values while rst is held low.
    #3;
    chk("rst.count", 128'(count), 128'(0));
    chk("rst.empty", 128'(empty), 128'(1));
    chk("rst.full", 128'(full), 128'(0));
    chk("rst.afull", 128'(almost_full), 128'(0));
    chk("rst.enq_ready", 128'(enq_ready), 128'(1));
    chk("rst.deq_valid", 128'(deq_valid), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Three enqueues, then three dequeues in order.
    cycle("e11", 1'b1, W'(8'h11), 1'b0, 1'b0);
    cycle("e22", 1'b1, W'(8'h22), 1'b0, 1'b0);
    cycle("e33", 1'b1, W'(8'h33), 1'b0, 1'b0);
    chk("seq.count3", 128'(count), 128'(3));
    chk("seq.head11", 128'(deq_data), 128'(8'h11));
    cycle("d11", 1'b0, '0, 1'b1, 1'b0);
    cycle("d22", 1'b0, '0, 1'b1, 1'b0);
    cycle("d33", 1'b0, '0, 1'b1, 1'b0);
    chk("seq.empty", 128'(empty), 128'(1));

    // Fill to full, then offer more while the consumer stalls.
    for (int i = 0; i < int'(DEPTH); i++) cycle("fill", 1'b1, rand_data(), 1'b0, 1'b0);
    chk("fill.full", 128'(full), 128'(1));
    for (int i = 0; i < 3; i++) cycle("full_stall", 1'b1, rand_data(), 1'b0, 1'b0);

    // Full queue streaming: simultaneous enq/deq for 20 cycles.
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, rand_data(), 1'b1, 1'b0);
    chk("stream.count", 128'(count), 128'(DEPTH));

    // Drain, load five entries, then flush alongside enq and deq.
    for (int i = 0; i < int'(DEPTH); i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("pre_flush", 1'b1, rand_data(), 1'b0, 1'b0);
    cycle("flush", 1'b1, W'(8'hEE), 1'b1, 1'b1);
    chk("flush.count", 128'(count), 128'(0));
    chk("flush.empty", 128'(empty), 128'(1));
    cycle("post_flush", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with four entries queued.
    for (int i = 0; i < 4; i++) cycle("pre_rst", 1'b1, rand_data(), 1'b0, 1'b0);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    #1;
    chk("arst.count", 128'(count), 128'(0));
    chk("arst.deq_valid", 128'(deq_valid), 128'(0));
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle("eAA", 1'b1, W'(8'hAA), 1'b0, 1'b0);
    chk("arst.headAA", 128'(deq_data), 128'(8'hAA));
    cycle("dAA", 1'b0, '0, 1'b1, 1'b0);

    // Enqueue into empty queue with ready consumer.
    cycle("byp5A", 1'b1, W'(8'h5A), 1'b1, 1'b0);
    chk("byp.count", 128'(count), 128'(BYP ? 0 : 1));
    cycle("after5A", 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), rand_data(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
